// File: rtl/pl_rx_pkg.sv
// Shared constants and types for the DVB-S2 PL receive path: SOF pattern, sync states,
// Gold-code seeds/taps and default frame geometry.
package pl_rx_pkg;

  localparam int unsigned SofLen      = 26;
  localparam logic [25:0] SofBits     = 26'h18D2E82;
  localparam int unsigned FrameLenDef = 21690;
  localparam int unsigned HdrLenDef   = 90;

  localparam logic [17:0] GoldXSeed = 18'h00001;
  localparam logic [17:0] GoldYSeed = 18'h3FFFF;
  // Register bit j holds sequence element (i + j); feedback masks pick the recurrence taps.
  localparam logic [17:0] GoldXFb   = 18'h00081;
  localparam logic [17:0] GoldYFb   = 18'h004A1;
  localparam logic [17:0] GoldXQ    = 18'h08050;
  localparam logic [17:0] GoldYQ    = 18'h3FF60;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StVerify = 2'd1,
    StLock   = 2'd2
  } pl_state_e;

  // Expected SOF symbol at window position n (0 = oldest); pi/2-BPSK on the 8PSK grid.
  function automatic logic [2:0] sof_sym(input int unsigned n);
    logic b;
    b = SofBits[5'(SofLen - 1 - n)];
    if (n % 2 == 0) return b ? 3'd5 : 3'd1;
    return b ? 3'd7 : 3'd3;
  endfunction

endpackage

// File: rtl/pl_gold_seq.sv
// DVB-S2 Gold scrambling sequence generator (code 0); r = 2*zq + zi for the current index.
module pl_gold_seq
  import pl_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seed,
  input  logic       step,
  output logic [1:0] r
);

  logic [17:0] x_q, x_d, y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (seed) begin
      x_d = GoldXSeed;
      y_d = GoldYSeed;
    end else if (step) begin
      x_d = {^(x_q & GoldXFb), x_q[17:1]};
      y_d = {^(y_q & GoldYFb), y_q[17:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign r = {(^(x_q & GoldXQ)) ^ (^(y_q & GoldYQ)), x_q[0] ^ y_q[0]};

endmodule

// File: rtl/pl_frame_sync_descrambler.sv
// DVB-S2 PL frame synchroniser: SOF search/verify/lock with flywheel, header strip and
// Gold-code descrambling of the payload symbols.
module pl_frame_sync_descrambler
  import pl_rx_pkg::*;
#(
  parameter int unsigned FRAME_LEN   = FrameLenDef,
  parameter int unsigned HDR_LEN     = HdrLenDef,
  parameter int unsigned SOF_ERR_TOL = 3,
  parameter int unsigned CONFIRM_N   = 2,
  parameter int unsigned MISS_N      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_sym,
  input  logic       i_valid,
  output logic [2:0] o_sym,
  output logic       o_valid,
  output logic       o_sof,
  output logic       o_locked,
  output logic [1:0] o_state
);

  localparam int unsigned FW = $clog2(FRAME_LEN);
  localparam int unsigned HW = $clog2(CONFIRM_N + 1);
  localparam int unsigned MW = $clog2(MISS_N + 1);

  localparam logic [FW-1:0] FidxLast    = FW'(FRAME_LEN - 1);
  localparam logic [FW-1:0] FidxChk     = FW'(SofLen - 1);
  localparam logic [FW-1:0] FidxLoad    = FW'(SofLen);
  localparam logic [FW-1:0] FidxHdrLast = FW'(HDR_LEN - 1);
  localparam logic [FW-1:0] FidxHdr     = FW'(HDR_LEN);
  localparam logic [4:0]    ErrTol      = 5'(SOF_ERR_TOL);
  localparam logic [HW-1:0] HitsDone    = HW'(CONFIRM_N);
  localparam logic [MW-1:0] MissDone    = MW'(MISS_N);

  pl_state_e           state_q, state_d;
  logic [FW-1:0]       fidx_q, fidx_d;
  logic [HW-1:0]       hits_q, hits_d;
  logic [MW-1:0]       miss_q, miss_d;
  logic [SofLen-2:0][2:0] win_q, win_d;
  logic [SofLen-1:0][2:0] cand;
  logic [2:0]          sym_q, sym_d;
  logic                valid_q, valid_d, sof_q, sof_d, locked_q;
  logic [4:0]          errs;
  logic                hit, chk;
  logic [1:0]          gold_r;

  // Window seen by the correlator includes the symbol being accepted this cycle.
  assign cand = {win_q, i_sym};

  always_comb begin
    errs = '0;
    for (int unsigned n = 0; n < SofLen; n++) begin
      errs = errs + 5'(cand[5'(SofLen - 1 - n)] != sof_sym(n));
    end
  end

  assign hit = (errs <= ErrTol);
  assign chk = (fidx_q == FidxChk);

  pl_gold_seq u_gold (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (i_valid && (fidx_q == FidxHdrLast)),
    .step  (i_valid && (fidx_q >= FidxHdr)),
    .r     (gold_r)
  );

  always_comb begin
    state_d = state_q;
    fidx_d  = fidx_q;
    hits_d  = hits_q;
    miss_d  = miss_q;
    win_d   = win_q;
    valid_d = 1'b0;
    sym_d   = '0;
    sof_d   = 1'b0;
    if (i_valid) begin
      win_d  = cand[SofLen-2:0];
      fidx_d = (fidx_q == FidxLast) ? '0 : fidx_q + FW'(1);
      unique case (state_q)
        StSearch: begin
          if (hit) begin
            state_d = StVerify;
            hits_d  = HW'(1);
            fidx_d  = FidxLoad;
          end
        end
        StVerify: begin
          if (chk) begin
            if (hit) begin
              hits_d = hits_q + HW'(1);
              if (hits_d == HitsDone) begin
                state_d = StLock;
                miss_d  = '0;
              end
            end else begin
              state_d = StSearch;
            end
          end
        end
        StLock: begin
          if (chk) begin
            if (hit) begin
              miss_d = '0;
            end else begin
              miss_d = miss_q + MW'(1);
              if (miss_d == MissDone) state_d = StSearch;
            end
          end
        end
        default: state_d = StSearch;
      endcase
      if ((state_q == StLock) && (fidx_q >= FidxHdr)) begin
        valid_d = 1'b1;
        sym_d   = i_sym - {gold_r, 1'b0};
        sof_d   = (fidx_q == FidxHdr);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StSearch;
      fidx_q   <= '0;
      hits_q   <= '0;
      miss_q   <= '0;
      win_q    <= '0;
      valid_q  <= 1'b0;
      sym_q    <= '0;
      sof_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fidx_q   <= fidx_d;
      hits_q   <= hits_d;
      miss_q   <= miss_d;
      win_q    <= win_d;
      valid_q  <= valid_d;
      sym_q    <= sym_d;
      sof_q    <= sof_d;
      locked_q <= (state_d == StLock);
    end
  end

  assign o_sym    = sym_q;
  assign o_valid  = valid_q;
  assign o_sof    = sof_q;
  assign o_locked = locked_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_pl_frame_sync_descrambler.sv
// Self-checking bench: builds scrambled PL frames with its own Gold model, drives them and
// compares descrambled output through a scoreboard queue plus state checkpoints.
module tb_pl_frame_sync_descrambler;

  localparam int unsigned FL = 600;
  localparam int unsigned HL = 90;
  localparam int unsigned PL = FL - HL;
  localparam logic [25:0] SOF = 26'h18D2E82;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] i_sym = '0;
  logic       i_valid = 1'b0;
  logic [2:0] o_sym;
  logic       o_valid, o_sof, o_locked;
  logic [1:0] o_state;

  always #5 clk = ~clk;

  pl_frame_sync_descrambler #(
    .FRAME_LEN   (FL),
    .HDR_LEN     (HL),
    .SOF_ERR_TOL (3),
    .CONFIRM_N   (2),
    .MISS_N      (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_sym    (i_sym),
    .i_valid  (i_valid),
    .o_sym    (o_sym),
    .o_valid  (o_valid),
    .o_sof    (o_sof),
    .o_locked (o_locked),
    .o_state  (o_state)
  );

  typedef struct {logic [2:0] sym; logic out; logic [2:0] d; logic sof;} sym_t;
  typedef struct {int unsigned idx; int st;} stchk_t;
  typedef struct {logic [2:0] rx; logic [2:0] exp_sym;} vec_t;
  typedef struct {logic [2:0] d; logic sof;} exp_t;

  sym_t        stream[$];
  stchk_t      stchk[$];
  exp_t        sb[$];
  vec_t        tbl[8];
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  int unsigned n_out = 0;
  logic        iv_seen = 1'b0;
  bit          gx[0:PL+31];
  bit          gy[0:PL+31];
  logic [1:0]  gold_r[0:PL-1];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [2:0] sof_sym(input int n);
    logic [25:0] s;
    s = SOF;
    if (n % 2 == 0) return s[25-n] ? 3'd5 : 3'd1;
    return s[25-n] ? 3'd7 : 3'd3;
  endfunction

  // One frame: SOF (optionally with errs symbol errors), random PLSC, scrambled payload.
  task automatic add_frame(input int errs, input bit out, input bit zero);
    sym_t e;
    logic [2:0] r2;
    for (int f = 0; f < int'(FL); f++) begin
      e.out = 1'b0;
      e.sof = 1'b0;
      e.d   = '0;
      if (f < 26) begin
        e.sym = sof_sym(f);
        if ((f % 7 == 2) && (f / 7 < errs)) e.sym = e.sym ^ 3'd1;
      end else if (f < int'(HL)) begin
        e.sym = 3'($urandom_range(0, 7));
      end else begin
        r2 = {gold_r[f - HL], 1'b0};
        e.d = zero ? 3'd0 - r2 : 3'($urandom_range(0, 7));
        e.sym = e.d + r2;
        if (zero && (f - int'(HL) < 8)) begin
          e.sym = tbl[f - HL].rx;
          e.d   = tbl[f - HL].exp_sym;
        end
        e.out = out;
        e.sof = (f == int'(HL));
      end
      stream.push_back(e);
    end
  endtask

  task automatic add_st(input int unsigned idx, input int st);
    stchk.push_back('{idx, st});
  endtask

  task automatic run_stream(input int unsigned duty, input int unsigned stop_at);
    sym_t e;
    int unsigned idx;
    idx = 0;
    forever begin
      @(posedge clk);
      #1;
      while (stchk.size() > 0 && stchk[0].idx <= idx) begin
        check($sformatf("o_state@%0d", stchk[0].idx), o_state, stchk[0].st);
        check($sformatf("o_locked@%0d", stchk[0].idx), o_locked, int'(stchk[0].st == 2));
        void'(stchk.pop_front());
      end
      if (stream.size() == 0 || (stop_at != 0 && idx == stop_at)) break;
      if ($urandom_range(0, 99) >= duty) begin
        i_valid = 1'b0;
        i_sym   = 3'($urandom_range(0, 7));
      end else begin
        e = stream.pop_front();
        i_sym   = e.sym;
        i_valid = 1'b1;
        if (e.out) sb.push_back('{e.d, e.sof});
        idx++;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic finish_phase(input string name, input int unsigned exp_out);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_out_count"}, n_out, exp_out);
    sb.delete();
    stchk.delete();
    n_out = 0;
  endtask

  always @(posedge clk) iv_seen <= i_valid;

  always @(negedge clk) begin
    if (rst_n && o_sof && !o_valid) check("o_sof_without_valid", o_sof, 0);
    if (rst_n && o_valid) begin
      n_out++;
      check("valid_after_gap", iv_seen, 1);
      if (sb.size() == 0) begin
        check("unexpected_o_valid", o_valid, 0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("o_sym", o_sym, x.d);
        check("o_sof", o_sof, x.sof);
      end
    end
  end

  initial begin
    // First payload vectors: received symbol and the required output for k = 0..7.
    tbl = '{'{3'd0, 3'd0}, '{3'd0, 3'd2}, '{3'd0, 3'd6}, '{3'd0, 3'd6},
            '{3'd3, 3'd1}, '{3'd7, 3'd1}, '{3'd5, 3'd3}, '{3'd6, 3'd0}};

    for (int i = 0; i < 18; i++) begin
      gx[i] = (i == 0);
      gy[i] = 1'b1;
    end
    for (int i = 18; i < int'(PL) + 32; i++) begin
      gx[i] = gx[i-11] ^ gx[i-18];
      gy[i] = gy[i-8] ^ gy[i-11] ^ gy[i-13] ^ gy[i-18];
    end
    for (int k = 0; k < int'(PL); k++) begin
      bit zq;
      zq = gx[k+4] ^ gx[k+6] ^ gx[k+15] ^ gy[k+5] ^ gy[k+6];
      for (int m = 8; m < 18; m++) zq = zq ^ gy[k+m];
      gold_r[k] = {zq, gx[k] ^ gy[k]};
    end

    // Clean stream, continuous valid.
    #2;
    check("reset_o_valid", o_valid, 0);
    check("reset_o_state", o_state, 0);
    check("reset_o_locked", o_locked, 0);
    do_reset();
    add_frame(0, 0, 0); add_frame(0, 1, 0); add_frame(0, 1, 0);
    add_st(25, 0); add_st(26, 1); add_st(FL + 25, 1); add_st(FL + 26, 2); add_st(3 * FL, 2);
    run_stream(100, 0);
    finish_phase("clean", 2 * PL);

    // Three SOF errors still acquire.
    do_reset();
    add_frame(3, 0, 0); add_frame(0, 1, 0); add_frame(0, 1, 0);
    add_st(26, 1); add_st(FL + 26, 2);
    run_stream(100, 0);
    finish_phase("err3", 2 * PL);

    // Four SOF errors: acquisition waits for the next clean SOF.
    do_reset();
    add_frame(4, 0, 0); add_frame(0, 0, 0); add_frame(0, 1, 0);
    add_st(26, 0); add_st(FL + 25, 0); add_st(FL + 26, 1); add_st(2 * FL + 26, 2);
    run_stream(100, 0);
    finish_phase("err4", PL);

    // Lock, then three corrupted SOFs: flywheel two frames, drop on the third.
    do_reset();
    add_frame(0, 0, 0); add_frame(0, 1, 0);
    add_frame(4, 1, 0); add_frame(4, 1, 0); add_frame(4, 0, 0); add_frame(0, 0, 0);
    add_st(FL + 26, 2); add_st(2 * FL + 26, 2); add_st(3 * FL + 26, 2);
    add_st(4 * FL + 25, 2); add_st(4 * FL + 26, 0); add_st(5 * FL + 26, 1);
    run_stream(100, 0);
    finish_phase("miss", 3 * PL);

    // Random 50% valid duty.
    do_reset();
    add_frame(0, 0, 0); add_frame(0, 1, 0); add_frame(0, 1, 0);
    add_st(25, 0); add_st(26, 1); add_st(FL + 25, 1); add_st(FL + 26, 2);
    run_stream(50, 0);
    finish_phase("gaps", 2 * PL);

    // Asynchronous reset in lock at fidx 200, then reacquisition.
    do_reset();
    add_frame(0, 0, 0); add_frame(0, 1, 0);
    run_stream(100, FL + 200);
    check("pre_reset_o_valid", o_valid, 1);
    rst_n = 1'b0;
    #2;
    check("async_rst_o_valid", o_valid, 0);
    check("async_rst_o_sym", o_sym, 0);
    check("async_rst_o_sof", o_sof, 0);
    check("async_rst_o_locked", o_locked, 0);
    check("async_rst_o_state", o_state, 0);
    stream.delete();
    sb.delete();
    n_out = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("post_rst_o_state", o_state, 0);
    add_frame(0, 0, 0); add_frame(0, 1, 0);
    add_st(25, 0); add_st(26, 1); add_st(FL + 25, 1); add_st(FL + 26, 2);
    run_stream(100, 0);
    finish_phase("reacq", PL);

    // All-zero received payload with known Gold values.
    do_reset();
    add_frame(0, 0, 0); add_frame(0, 1, 1);
    add_st(FL + 26, 2);
    run_stream(100, 0);
    finish_phase("zero", PL);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pl_frame_sync_descrambler.md
Name: pl_frame_sync_descrambler

Overview:
Receive-side counterpart of the DVB-S2 PL framer and scrambler.
- Input: hard-decided 8PSK symbol indices (0..7, phase = k*45 deg; carrier phase already resolved upstream).
- Finds the 26-symbol SOF, acquires and flywheels frame timing over 21690-symbol PL frames, strips the 90-symbol PL header, removes the Gold-code scrambling from the 21600 payload symbols.
- Sits between symbol slicer and de-mapper.

Parameters:
FRAME_LEN, 21690, symbols per PL frame including header
HDR_LEN, 90, PL header symbols (SOF + PLSC)
SOF_ERR_TOL, 3, max symbol mismatches in the 26-symbol window still counted as SOF hit
CONFIRM_N, 2, consecutive SOF hits at FRAME_LEN spacing needed to enter LOCK
MISS_N, 3, consecutive SOF misses in LOCK before returning to SEARCH

Ports:
clk  in  1  symbol-domain clock
rst_n  in  1  asynchronous, active-low reset
i_sym  in  3  received symbol index
i_valid  in  1  i_sym qualifier; all counters advance only when high
o_sym  out  3  descrambled payload symbol
o_valid  out  1  o_sym qualifier
o_sof  out  1  high with o_valid on first payload symbol of a frame
o_locked  out  1  state == LOCK
o_state  out  2  0 SEARCH, 1 VERIFY, 2 LOCK

Behaviour:
- One clock: clk. Reset: rst_n, asynchronous, active-low. Reset clears state to SEARCH, window, counters and Gold LFSRs. All outputs are 0 in reset. Reset mid-frame drops the frame, with no output afterwards until reacquired.
- SOF window: 26-deep shift register of i_sym, shifted on i_valid. Expected symbol n (n=0 oldest):
  - SOF bit b = bit (25-n) of 0x18D2E82.
  - Even n: b=0 -> 1, b=1 -> 5. Odd n: b=0 -> 3, b=1 -> 7.
  - hit = (mismatch count over the 26 positions, including the just-accepted symbol) <= SOF_ERR_TOL.
- Frame counter fidx, 0..FRAME_LEN-1. Increments per accepted symbol and wraps FRAME_LEN-1 -> 0. On a SEARCH hit it is loaded so the next accepted symbol has fidx = 26. The SOF check point is the accepted symbol with fidx == 25.
- SEARCH: hit on any accepted symbol -> VERIFY, hit count = 1.
- VERIFY: at the check point, hit -> count+1, and if count reaches CONFIRM_N -> LOCK. Miss -> SEARCH. Off-checkpoint hits are ignored.
- LOCK: at the check point, hit clears the miss counter. Miss increments it, and at MISS_N -> SEARCH. Until then the block flywheels and keeps emitting payload.
- Payload is output only in LOCK, including the frame whose SOF caused the VERIFY->LOCK transition.
- Symbols with fidx < HDR_LEN are never output; the PLSC is discarded.
- Descrambling: R(k) is the 2-bit DVB-S2 Gold sequence (EN 302 307 5.5.4, scrambling code 0), produced by sub-module.
  - LFSRs are re-seeded when the accepted symbol has fidx == HDR_LEN-1.
  - They step once per accepted payload symbol, so k = fidx-HDR_LEN.
  - o_sym = (i_sym - 2*R(k)) mod 8 (3-bit wrap).
- Latency: one cycle. o_valid/o_sym/o_sof are registered from the accepted i_valid cycle. o_sof is high when fidx == HDR_LEN.
- i_valid gaps: counters, window and LFSR hold, and o_valid is 0.
- A SEARCH->VERIFY hit on a symbol that is also the fidx wrap point uses the load value, not the increment.
- State transitions take effect on the cycle after the check-point symbol. o_locked and o_state are registered.

Decomposition:
- Package pl_rx_pkg holds:
  - SOF constant (26'h18D2E82) and the bit-to-symbol mapping function;
  - state enum (SEARCH/VERIFY/LOCK);
  - Gold seeds (x = 18'h00001, y = 18'h3FFFF) and feedback tap constants;
  - FRAME_LEN/HDR_LEN defaults.
- Sub-module pl_gold_seq (in: clk, rst_n, seed, step; out: R[1:0]) holds both 18-bit LFSRs and the zi/zq taps. It mirrors the transmitter GoldCode generator so the two can be cross-checked.

Test Plan:
- Clean stream: three frames built with the team's transmit model, i_valid = 1 always. Required response:
  - state 0 -> 1 at symbol 25;
  - state 1 -> 2 one cycle after the second SOF check point (stream symbol 21715);
  - o_sof on stream symbol 21780;
  - 21600 o_valid per locked frame, o_sym matching the transmitter's unscrambled symbols.
- SOF with 3 symbol errors -> still hit. SOF with 4 errors in the first frame -> no VERIFY entry until the next clean SOF.
- Locked stream where three consecutive SOFs are corrupted (4 errors each):
  - payload is still output for the first two corrupted frames;
  - state goes to SEARCH right after the third check point and o_valid stops.
- Random i_valid (50% duty) over two frames -> output sequence identical to the continuous case. No o_valid while i_valid was low the prior cycle.
- rst_n pulled low at fidx = 5000 in LOCK -> all outputs 0 asynchronously. After release, o_state = 0 and reacquisition follows the clean-stream timing.
- Payload of all symbol 0 with known R -> o_sym equals (0 - 2*R) mod 8. First 4 R values match the reference Gold model output.
